// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the on-chip memory copy/fill master.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 15;

  localparam logic MODE_FILL = 1'b1;
  localparam logic MODE_COPY = 1'b0;

endpackage

// File: rtl/mem_copy_checksum.sv
// Running modulo-2^DATA_W sum of committed write data, cleared on command accept.
module mem_copy_checksum #(
  parameter int DATA_W = mem_copy_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM block fill/copy master for a single-port on-chip RAM with 1-cycle read latency.
// Optional write-data checksum enabled by defining MEM_COPY_CHECKSUM_EN.
module onchip_mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_fill,
  input  logic [ADDR_W-1:0]     cmd_src,
  input  logic [ADDR_W-1:0]     cmd_dst,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_W-1:0]     cmd_pattern,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;

  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign cmd_ready = (state_q == IDLE) && !hold;
  assign accept    = cmd_valid && cmd_ready;
  assign last_word = (idx_q == (len_q - LEN_W'(1)));
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign rd_addr   = src_q + idx_q[ADDR_W-1:0];
  assign wr_addr   = dst_q + idx_q[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            src_d     = cmd_src;
            dst_d     = cmd_dst;
            len_d     = cmd_len;
            fill_d    = cmd_fill;
            pattern_d = cmd_pattern;
            idx_d     = '0;
            if (cmd_len == '0) begin
              state_d = DONE;
            end else if (cmd_fill == MODE_FILL) begin
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
        READ: begin
          state_d = WRITE;
        end
        WRITE: begin
          idx_d = idx_q + LEN_W'(1);
          if (last_word) begin
            state_d = DONE;
          end else if (fill_q == MODE_FILL) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode the frozen state, so hold keeps them stable for free.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    case (state_q)
      READ: begin
        mem_chipselect = 1'b1;
        mem_address    = rd_addr;
      end
      WRITE: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = wr_addr;
        mem_writedata  = (fill_q == MODE_FILL) ? pattern_q : mem_readdata;
      end
      default: begin
        mem_chipselect = 1'b0;
      end
    endcase
  end

  assign mem_byteenable = {BE_W{mem_chipselect}};
  assign mem_clken      = !hold;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Command fields only matter once a command is accepted.
  always_ff @(posedge clk) begin
    src_q     <= src_d;
    dst_q     <= dst_d;
    len_q     <= len_d;
    fill_q    <= fill_d;
    pattern_q <= pattern_d;
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic commit;
  assign commit = (state_q == WRITE) && !hold;

  mem_copy_checksum #(
    .DATA_W (DATA_W)
  ) u_checksum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (commit),
    .din     (mem_writedata),
    .sum     (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master with an altsyncram-style memory model and access scoreboard.
module tb_onchip_mem_copy_master;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 15;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BE_W   = DATA_W / 8;

  logic                clk;
  logic                reset_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_fill;
  logic [ADDR_W-1:0]   cmd_src;
  logic [ADDR_W-1:0]   cmd_dst;
  logic [LEN_W-1:0]    cmd_len;
  logic [DATA_W-1:0]   cmd_pattern;
  logic                hold;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   checksum;
  logic [ADDR_W-1:0]   mem_address;
  logic [BE_W-1:0]     mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  onchip_mem_copy_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_fill       (cmd_fill),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_len        (cmd_len),
    .cmd_pattern    (cmd_pattern),
    .hold           (hold),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered address, unregistered q, clock enable; plus a bench preload port.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [ADDR_W-1:0] addr_reg;
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  assign mem_readdata = mem[addr_reg];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_clken) begin
      if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
      addr_reg <= mem_address;
    end
  end

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   checks;
  int   errors;
  logic mon_en;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every committed bus access must match the next expected one.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("byteenable", 64'(mem_byteenable), mem_chipselect ? 64'({BE_W{1'b1}}) : 64'd0);
      if (mem_chipselect && mem_clken) begin
        chk("access_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          acc_t e;
          e = exp_q.pop_front();
          chk("access_kind", 64'(mem_write), 64'(e.wr));
          chk("access_addr", 64'(mem_address), 64'(e.addr));
          if (e.wr) chk("write_data", 64'(mem_writedata), 64'(e.data));
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [ADDR_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      chk(tag, 64'(mem[a]), 64'(ref_mem[a]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_ready"},  64'(cmd_ready), 64'd1);
    chk({tag, "_cs"},     64'(mem_chipselect), 64'd0);
    chk({tag, "_wr"},     64'(mem_write), 64'd0);
    chk({tag, "_addr"},   64'(mem_address), 64'd0);
    chk({tag, "_wdata"},  64'(mem_writedata), 64'd0);
    chk({tag, "_be"},     64'(mem_byteenable), 64'd0);
    chk({tag, "_clken"},  64'(mem_clken), 64'd1);
    chk({tag, "_csum"},   64'(checksum), 64'd0);
  endtask

  task automatic run_cmd(input string tag, input logic fill, input logic [ADDR_W-1:0] src,
                         input logic [ADDR_W-1:0] dst, input logic [LEN_W-1:0] len,
                         input logic [DATA_W-1:0] pat, input int hold_at, input int hold_len,
                         input bit junk);
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   exp_cs;
    logic [ADDR_W+1:0]   frz;
    int                  exp_lat;
    int                  c;
    acc_t                e;
    sum = '0;
    frz = '0;
    for (int i = 0; i < int'(len); i++) begin
      logic [ADDR_W-1:0] a_s, a_d;
      logic [DATA_W-1:0] d;
      a_s = src + ADDR_W'(i);
      a_d = dst + ADDR_W'(i);
      if (fill) begin
        d = pat;
      end else begin
        e.wr = 1'b0; e.addr = a_s; e.data = '0;
        exp_q.push_back(e);
        d = ref_mem[a_s];
      end
      e.wr = 1'b1; e.addr = a_d; e.data = d;
      exp_q.push_back(e);
      ref_mem[a_d] = d;
      sum = sum + d;
    end
`ifdef MEM_COPY_CHECKSUM_EN
    exp_cs = sum;
`else
    exp_cs = '0;
`endif
    exp_lat = (len == 0) ? 1 : (fill ? int'(len) + 1 : 2 * int'(len) + 1);
    if (hold_at > 0) exp_lat = exp_lat + hold_len;

    cmd_fill = fill; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
    cmd_valid = 1'b1;
    #1;
    chk({tag, "_ready_before"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 1;
    while (!done && c < exp_lat + 20) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (hold_at > 0 && c >= hold_at && c < hold_at + hold_len) begin
        hold = 1'b1;
        #1;
        chk({tag, "_hold_clken"}, 64'(mem_clken), 64'd0);
        chk({tag, "_hold_ready"}, 64'(cmd_ready), 64'd0);
        if (c == hold_at) frz = {mem_chipselect, mem_write, mem_address};
        else chk({tag, "_hold_frozen"}, 64'({mem_chipselect, mem_write, mem_address}), 64'(frz));
      end else begin
        hold = 1'b0;
        #1;
        chk({tag, "_clken"}, 64'(mem_clken), 64'd1);
      end
      if (junk && c == 2) begin
        cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_dst = dst + ADDR_W'(100); cmd_len = 15'd2;
        cmd_pattern = 32'h0BAD_0BAD;
        chk({tag, "_ready_busy"}, 64'(cmd_ready), 64'd0);
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    hold = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_done_cycle"}, 64'(c), 64'(exp_lat));
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    chk({tag, "_checksum"}, 64'(checksum), 64'(exp_cs));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_checksum_stable"}, 64'(checksum), 64'(exp_cs));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    reset_n = 1'b0; hold = 1'b0; cmd_valid = 1'b0; cmd_fill = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_pattern = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) preload(ADDR_W'(i), '0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Fill with a busy-time command that must be ignored.
    run_cmd("fill4", 1'b1, 14'h0000, 14'h0010, 15'd4, 32'hDEADBEEF, 0, 0, 1'b1);
    check_mem("fill4_mem", 14'h0010, 4);
    chk("fill4_word0", 64'(mem[14'h0010]), 64'h0000_0000_DEAD_BEEF);
    chk("fill4_untouched", 64'(mem[14'h0014]), 64'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("fill4_csum_const", 64'(checksum), 64'h7AB6_FBBC);
`endif

    preload(14'h0100, 32'd1);
    preload(14'h0101, 32'd2);
    preload(14'h0102, 32'd3);
    run_cmd("copy3", 1'b0, 14'h0100, 14'h0200, 15'd3, '0, 0, 0, 1'b0);
    check_mem("copy3_mem", 14'h0200, 3);

    preload(14'h3FFE, 32'hAAAA_0001);
    preload(14'h3FFF, 32'hAAAA_0002);
    preload(14'h0000, 32'hAAAA_0003);
    preload(14'h0001, 32'hAAAA_0004);
    run_cmd("copywrap", 1'b0, 14'h3FFE, 14'h0000, 15'd4, '0, 0, 0, 1'b0);
    check_mem("copywrap_dst", 14'h0000, 4);
    check_mem("copywrap_src", 14'h3FFE, 2);

    run_cmd("fill0", 1'b1, 14'h0000, 14'h0700, 15'd0, 32'h5555_5555, 0, 0, 1'b0);
    check_mem("fill0_mem", 14'h0700, 1);

    for (int i = 0; i < 5; i++) preload(14'h0600 + 14'(i), $urandom);
    run_cmd("overlap", 1'b0, 14'h0600, 14'h0602, 15'd5, '0, 0, 0, 1'b0);
    check_mem("overlap_mem", 14'h0600, 7);

    for (int i = 0; i < 3; i++) preload(14'h0400 + 14'(i), $urandom);
    run_cmd("copyhold", 1'b0, 14'h0400, 14'h0500, 15'd3, '0, 3, 3, 1'b0);
    check_mem("copyhold_mem", 14'h0500, 3);

    // Reset three writes into an eight-word fill.
    begin
      acc_t e;
      for (int i = 0; i < 3; i++) begin
        e.wr = 1'b1; e.addr = 14'h0300 + 14'(i); e.data = 32'h1234_5678;
        exp_q.push_back(e);
        ref_mem[14'h0300 + 14'(i)] = 32'h1234_5678;
      end
      cmd_fill = 1'b1; cmd_src = '0; cmd_dst = 14'h0300; cmd_len = 15'd8;
      cmd_pattern = 32'h1234_5678; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("midreset");
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        chk("midreset_no_done", 64'(done), 64'd0);
        chk("midreset_no_cs", 64'(mem_chipselect), 64'd0);
      end
      check_mem("midreset_mem", 14'h0300, 8);
      chk("midreset_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_copy_master.md
# onchip_mem_copy_master

Avalon-MM master that drives the single-port on-chip memory slave (s1/s2 style: address, byteenable, chipselect, write, writedata, clken, readdata) to fill or copy word blocks without processor involvement. A Nios core or control FSM issues a one-cycle command; the block sequences reads and writes against the memory's fixed 1-cycle read latency, then pulses done. It sits beside each MPSoC on-chip memory as a local block mover or initialiser.

## Interface
- ADDR_W, 14, word address width; matches memory widthad
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 15, length width in words; max length 2^ADDR_W
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_fill  in  1  1 = fill with cmd_pattern, 0 = copy src to dst
- cmd_src  in  ADDR_W  copy source word address
- cmd_dst  in  ADDR_W  destination word address
- cmd_len  in  LEN_W  number of words
- cmd_pattern  in  DATA_W  fill value
- hold  in  1  stall request; freezes the block and gates memory clken
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_W  sum of written words (see Configuration)
- mem_address  out  ADDR_W, mem_byteenable  out  DATA_W/8, mem_chipselect  out  1, mem_write  out  1, mem_writedata  out  DATA_W, mem_clken  out  1: master side to memory
- mem_readdata  in  DATA_W  memory read data, valid one cycle after the read address is presented

## Operation
- States: IDLE, READ, WRITE, DONE.
- cmd_ready = (state==IDLE) & ~hold. Accept on cmd_valid & cmd_ready: latch src, dst, len, fill, pattern; clear index and checksum.
- Accept with cmd_len==0: go directly to DONE; no memory access.
- Fill: IDLE -> WRITE; each WRITE cycle drives dst+i, chipselect=1, write=1, writedata=pattern; i++ ; after last word -> DONE.
- Copy: IDLE -> READ; READ drives src+i, chipselect=1, write=0 -> WRITE; WRITE drives dst+i, write=1, writedata=mem_readdata (combinational forward) ; i++ ; -> READ, or DONE after last word.
- Copy is forward/ascending with read of index i before write of index i; overlapping regions yield sequential forward-copy semantics.
- Address arithmetic modulo 2^ADDR_W (wraps through top of memory).
- mem_byteenable = all ones whenever chipselect=1; all zeros otherwise.
- DONE: done=1 for one cycle, then IDLE. busy=1 in READ, WRITE, DONE.
- hold=1 outside IDLE: state, index, checksum frozen; mem_clken=0; bus outputs held at current values (memory ignores them; memory output held).
- Reset: state=IDLE; outputs next cycle: cmd_ready=1 (if hold=0), busy=0, done=0, checksum=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, mem_clken=1. Reset mid-operation aborts immediately; partial writes stand.

## Timing
- Command accepted at edge T (no hold).
- Fill length N: writes in cycles T+1..T+N; done at T+N+1; cmd_ready at T+N+2.
- Copy length N: read i at T+1+2i, write i at T+2+2i; done at T+2N+1.
- Length 0: done at T+1.
- Each cycle with hold=1 outside IDLE extends all subsequent events by one cycle.
- mem_clken=1 whenever hold=0.

## Configuration
- MEM_COPY_CHECKSUM_EN defined: checksum accumulates writedata (modulo 2^DATA_W) on every committed write (WRITE state, hold=0); value stable from done until next accept.
- Undefined: no accumulator; checksum tied to 0.

## Structure
- Package mem_copy_pkg: state enum (IDLE, READ, WRITE, DONE), default width constants, MODE_FILL/MODE_COPY constants.
- Sub-module mem_copy_checksum: accumulator with clear, enable, data in; instantiated only under MEM_COPY_CHECKSUM_EN.
- Bench uses an altsyncram-equivalent model (registered address, unregistered q, clken).

## Test plan
- Fill dst=0x0010, len=4, pattern=0xDEADBEEF -> writes at T+1..T+4 to 0x10..0x13, done at T+5, words read back 0xDEADBEEF, checksum=0x7AB6FBBC (with macro).
- Copy src=0x0100 (preloaded 1,2,3), dst=0x0200, len=3 -> reads/writes alternate, done at T+7, 0x200..0x202 = 1,2,3, checksum=6.
- Copy src=0x3FFE, dst=0x0000, len=4 -> source wraps 0x3FFE,0x3FFF,0x0000,0x0001; forward semantics on overlap verified against reference model.
- Fill len=0 -> no chipselect, done at T+1; cmd_ready=0 while busy, second cmd_valid ignored until IDLE.
- hold=1 for 3 cycles mid-copy -> mem_clken=0 those cycles, outputs frozen, done delayed by exactly 3, data correct.
- reset_n=0 during fill of 8 words after 3 writes -> next cycle IDLE, busy=0, done never pulses, only first 3 words modified.
